pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It produces the select and enable signals consumed by the IF PC select, the ID/EX pipeline registers and the EX stage.
- Keeps a 3-deep scoreboard of in-flight GPR destinations (EX, MEM, WB).
- Stalls ID on read-after-write hazards; the pipeline has no forwarding, so this is stall-only.
- Holds EX for multi-cycle multiply/divide.
- Redirects and flushes IF when ID resolves a taken branch or jump.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/hazard_scoreboard.sv | 52 +++++
 rtl/pipe_hazard_ctrl.sv | 84 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam logic [4:0] REG_RA    = 5'd31;
  localparam int         MDU_CNT_W = 4;

  // One in-flight GPR destination tracked by the scoreboard.
  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
  } sb_entry_t;

  // True when a valid in-flight destination matches a source register.
  function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] r);
    return e.valid && (e.addr == r);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry EX/MEM/WB destination scoreboard with RAW match logic for rs/rt.
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_hold_i,
  input  sb_entry_t  new_entry_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       use_rs_i,
  input  logic       use_rt_i,
  output logic       raw_rs_o,
  output logic       raw_rt_o
);

  sb_entry_t sb_ex_q, sb_mem_q, sb_wb_q;
  sb_entry_t sb_ex_d, sb_mem_d, sb_wb_d;

  // Shift destinations down the pipe; on an EX hold the held instruction stays and MEM gets a bubble.
  always_comb begin
    sb_wb_d  = sb_mem_q;
    sb_mem_d = sb_ex_q;
    sb_ex_d  = new_entry_i;
    if (ex_hold_i) begin
      sb_mem_d = '0;
      sb_ex_d  = sb_ex_q;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_ex_q  <= '0;
      sb_mem_q <= '0;
      sb_wb_q  <= '0;
    end else begin
      sb_ex_q  <= sb_ex_d;
      sb_mem_q <= sb_mem_d;
      sb_wb_q  <= sb_wb_d;
    end
  end

  // WB is still a hazard because the register file writes at the edge that ends WB; $0 never is.
  always_comb begin
    raw_rs_o = use_rs_i && (rs_i != REG_ZERO) &&
               (sb_hit(sb_ex_q, rs_i) || sb_hit(sb_mem_q, rs_i) || sb_hit(sb_wb_q, rs_i));
    raw_rt_o = use_rt_i && (rt_i != REG_ZERO) &&
               (sb_hit(sb_ex_q, rt_i) || sb_hit(sb_mem_q, rt_i) || sb_hit(sb_wb_q, rt_i));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: RAW stalls, MDU EX hold, branch redirect and stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wen,
  input  logic [4:0]       id_waddr,
  input  logic             id_is_mdu,
  input  logic             id_branch_taken,
  output logic             pc_stall,
  output logic             if_id_flush,
  output logic             if_pc_sel,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic                 raw_rs, raw_rt, raw, issue;
  sb_entry_t            new_entry;
  logic [MDU_CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  hazard_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .ex_hold_i   (ex_hold),
    .new_entry_i (new_entry),
    .rs_i        (id_rs),
    .rt_i        (id_rt),
    .use_rs_i    (id_use_rs),
    .use_rt_i    (id_use_rt),
    .raw_rs_o    (raw_rs),
    .raw_rt_o    (raw_rt)
  );

  // Stall/flush decisions: MDU hold outranks RAW, which outranks a branch redirect.
  always_comb begin
    raw             = id_valid && (raw_rs || raw_rt);
    mdu_busy        = (mdu_cnt_q != '0);
    ex_hold         = mdu_busy;
    pc_stall        = raw || mdu_busy;
    id_ex_bubble    = raw && !mdu_busy;
    issue           = id_valid && !pc_stall;
    if_pc_sel       = issue && id_branch_taken;
    if_id_flush     = if_pc_sel;
    new_entry.valid = issue && id_wen && (id_waddr != REG_ZERO);
    new_entry.addr  = id_waddr;
  end

  // MDU occupancy count and stall counter next state.
  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (issue && id_is_mdu && !ex_hold) begin
      mdu_cnt_d = MDU_CNT_W'(MDU_CYCLES - 1);
    end else if (mdu_cnt_q != '0) begin
      mdu_cnt_d = mdu_cnt_q - 1'b1;
    end
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, pc_stall};
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      mdu_cnt_q   <= mdu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MDU_CYCLES = 4).
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_use_rs, id_use_rt, id_wen, id_is_mdu, id_branch_taken;
  logic [4:0]       id_rs, id_rt, id_waddr;
  logic             pc_stall, if_id_flush, if_pc_sel, id_ex_bubble, ex_hold, mdu_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [5:0]       ctl;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_stall = 0;

  // {pc_stall, if_id_flush, if_pc_sel, id_ex_bubble, ex_hold, mdu_busy}
  localparam logic [5:0] C_CLEAN = 6'b000000;
  localparam logic [5:0] C_RAW   = 6'b100100;
  localparam logic [5:0] C_MDU   = 6'b100011;
  localparam logic [5:0] C_BR    = 6'b011000;

  assign ctl = {pc_stall, if_id_flush, if_pc_sel, id_ex_bubble, ex_hold, mdu_busy};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wen(id_wen), .id_waddr(id_waddr), .id_is_mdu(id_is_mdu),
    .id_branch_taken(id_branch_taken),
    .pc_stall(pc_stall), .if_id_flush(if_id_flush), .if_pc_sel(if_pc_sel),
    .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .mdu_busy(mdu_busy),
    .stall_cycles(stall_cycles)
  );

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wen,
                       input logic [4:0] wa, input logic mdu, input logic br);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wen = wen; id_waddr = wa; id_is_mdu = mdu; id_branch_taken = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 5'd7, 5'd7, 1, 1, 1, 5'd7, 0, 1);
    n_cmp++; if (ctl !== 6'b011000) begin n_bad++; $display("FAIL reset_br_idle ctl=%b exp=%b", ctl, 6'b011000); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (ctl !== C_CLEAN) begin n_bad++; $display("FAIL reset_ctl ctl=%b exp=%b", ctl, C_CLEAN); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
    #10 rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0);           // addu $3,$1,$2
    n_cmp++; if (ctl !== C_CLEAN) begin n_bad++; $display("FAIL b2b_writer ctl=%b exp=%b", ctl, C_CLEAN); end
    tick();
    drive(1, 5'd3, 5'd3, 1, 1, 1, 5'd4, 0, 0);           // addu $4,$3,$3
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ctl !== C_RAW) begin n_bad++; $display("FAIL b2b_stall%0d ctl=%b exp=%b", i, ctl, C_RAW); end
      tick();
    end
    n_cmp++; if (ctl !== C_CLEAN) begin n_bad++; $display("FAIL b2b_issue ctl=%b exp=%b", ctl, C_CLEAN); end
    exp_stall += 3;
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", stall_cycles, exp_stall); end
    tick();
    drain();
  endtask

  task automatic test_zero_reg();
    drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd0, 0, 0);           // write $0
    tick();
    drive(1, 5'd0, 5'd0, 1, 1, 1, 5'd9, 0, 0);           // read $0
    n_cmp++; if (ctl !== C_CLEAN) begin n_bad++; $display("FAIL zero_read ctl=%b exp=%b", ctl, C_CLEAN); end
    tick();
    drain();
  endtask

  task automatic test_gap3();
    drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0); tick();   // writes $3
    drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd8, 0, 0); tick();   // unrelated
    drive(1, 5'd2, 5'd1, 1, 1, 1, 5'd9, 0, 0); tick();   // unrelated
    drive(1, 5'd3, 5'd0, 1, 0, 1, 5'd10, 0, 0);          // reads $3 via rs
    n_cmp++; if (ctl !== C_RAW) begin n_bad++; $display("FAIL gap3_stall ctl=%b exp=%b", ctl, C_RAW); end
    tick();
    n_cmp++; if (ctl !== C_CLEAN) begin n_bad++; $display("FAIL gap3_issue ctl=%b exp=%b", ctl, C_CLEAN); end
    exp_stall += 1;
    tick();
    drain();
  endtask

  task automatic test_branch_hazard();
    drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd5, 0, 0); tick();   // writes $5
    drive(1, 5'd5, 5'd6, 1, 1, 0, 5'd0, 0, 1);           // beq $5,$6 taken
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ctl !== C_RAW) begin n_bad++; $display("FAIL br_stall%0d ctl=%b exp=%b", i, ctl, C_RAW); end
      tick();
    end
    n_cmp++; if (ctl !== C_BR) begin n_bad++; $display("FAIL br_redirect ctl=%b exp=%b", ctl, C_BR); end
    exp_stall += 3;
    tick();
    drive(0, 5'd5, 5'd6, 1, 1, 0, 5'd0, 0, 1);           // squashed slot
    n_cmp++; if (ctl !== C_CLEAN) begin n_bad++; $display("FAIL br_once ctl=%b exp=%b", ctl, C_CLEAN); end
    drain();
  endtask

  task automatic test_mdu();
    drive(1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 0);           // div $1,$2
    n_cmp++; if (ctl !== C_CLEAN) begin n_bad++; $display("FAIL mdu_issue ctl=%b exp=%b", ctl, C_CLEAN); end
    tick();
    drive(1, 5'd11, 5'd12, 1, 1, 1, 5'd13, 0, 0);        // independent add
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ctl !== C_MDU) begin n_bad++; $display("FAIL mdu_hold%0d ctl=%b exp=%b", i, ctl, C_MDU); end
      tick();
    end
    n_cmp++; if (ctl !== C_CLEAN) begin n_bad++; $display("FAIL mdu_add_issue ctl=%b exp=%b", ctl, C_CLEAN); end
    exp_stall += 3;
    tick();
    drain();
  endtask

  task automatic test_mdu_sb_bubble();
    drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd10, 0, 0); tick();  // writes $10
    drive(1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 0); tick();   // div
    drive(1, 5'd10, 5'd0, 1, 0, 1, 5'd14, 0, 0);         // reads $10 behind div
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ctl !== C_MDU) begin n_bad++; $display("FAIL mdusb_hold%0d ctl=%b exp=%b", i, ctl, C_MDU); end
      tick();
    end
    n_cmp++; if (ctl !== C_CLEAN) begin n_bad++; $display("FAIL mdusb_issue ctl=%b exp=%b", ctl, C_CLEAN); end
    exp_stall += 3;
    tick();
    drain();
  endtask

  task automatic test_jal_jr();
    drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd31, 0, 1);          // jal
    n_cmp++; if (ctl !== C_BR) begin n_bad++; $display("FAIL jal_redirect ctl=%b exp=%b", ctl, C_BR); end
    tick();
    drive(1, 5'd31, 5'd0, 1, 0, 0, 5'd0, 0, 1);          // jr $31
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ctl !== C_RAW) begin n_bad++; $display("FAIL jr_stall%0d ctl=%b exp=%b", i, ctl, C_RAW); end
      tick();
    end
    n_cmp++; if (ctl !== C_BR) begin n_bad++; $display("FAIL jr_redirect ctl=%b exp=%b", ctl, C_BR); end
    exp_stall += 3;
    tick();
    drain();
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL total_cnt got=%0d exp=%0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_reset_mid_hold();
    drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd7, 0, 0); tick();   // writes $7
    drive(1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 0); tick();   // div; $7 now in MEM
    drive(1, 5'd7, 5'd0, 1, 0, 1, 5'd15, 0, 0);          // reads $7
    n_cmp++; if (ctl !== C_MDU) begin n_bad++; $display("FAIL rstmid_pre ctl=%b exp=%b", ctl, C_MDU); end
    rst = 1'b1;
    #1;
    n_cmp++; if (ctl !== C_CLEAN) begin n_bad++; $display("FAIL rstmid_ctl ctl=%b exp=%b", ctl, C_CLEAN); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL rstmid_cnt got=%0d exp=0", stall_cycles); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (ctl !== C_CLEAN) begin n_bad++; $display("FAIL rstmid_reader ctl=%b exp=%b", ctl, C_CLEAN); end
    tick();
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL rstmid_cnt_after got=%0d exp=0", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_zero_reg();
    test_gap3();
    test_branch_hazard();
    test_mdu();
    test_mdu_sb_bubble();
    test_jal_jr();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
